// File: rtl/accumulator_binary_saturating_pkg.sv
// Shared opcode encoding and datapath extension constant for the saturating accumulator.
package accumulator_binary_saturating_pkg;

  // Operation selected by in_add_sub
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Guard bits added above WORD_WIDTH so add/sub of two WORD_WIDTH values never wraps
  localparam int unsigned EXT_BITS = 1;

endpackage

// File: rtl/accumulator_binary_saturating_adder_subtractor.sv
// Combinational extend / add-subtract / clip datapath for the saturating accumulator.
// Subtraction treats carry_i as a borrow: acc - operand - carry_i.
module Adder_Subtractor_Binary_Saturating
  import accumulator_binary_saturating_pkg::*;
#(
  parameter int WORD_WIDTH = 0
) (
  input  logic signed [WORD_WIDTH-1:0] acc_i,
  input  logic signed [WORD_WIDTH-1:0] operand_i,
  input  logic                         op_i,
  input  logic                         carry_i,
  input  logic                         load_i,
  input  logic signed [WORD_WIDTH-1:0] max_i,
  input  logic signed [WORD_WIDTH-1:0] min_i,
  output logic        [WORD_WIDTH-1:0] result_o,
  output logic                         sat_high_o,
  output logic                         sat_low_o,
  output logic                         carry_o
);

  localparam int unsigned EXT_W = WORD_WIDTH + EXT_BITS;

  logic signed [EXT_W-1:0] acc_x;
  logic signed [EXT_W-1:0] opd_x;
  logic signed [EXT_W-1:0] cin_x;
  logic signed [EXT_W-1:0] max_x;
  logic signed [EXT_W-1:0] min_x;
  logic signed [EXT_W-1:0] sum_x;

  // Sign-extend, compute unclipped result, then clip with min taking priority
  always_comb begin
    acc_x      = EXT_W'(acc_i);
    opd_x      = EXT_W'(operand_i);
    cin_x      = EXT_W'({1'b0, carry_i});
    max_x      = EXT_W'(max_i);
    min_x      = EXT_W'(min_i);
    sum_x      = '0;
    result_o   = '0;
    sat_high_o = 1'b0;
    sat_low_o  = 1'b0;
    carry_o    = 1'b0;

    if (load_i) begin
      sum_x = opd_x;
    end else if (op_e'(op_i) == OP_SUB) begin
      sum_x = acc_x - opd_x - cin_x;
    end else begin
      sum_x = acc_x + opd_x + cin_x;
    end

    carry_o = load_i ? 1'b0 : sum_x[EXT_W-1];

    if (sum_x < min_x) begin
      result_o  = min_i;
      sat_low_o = 1'b1;
    end else if (sum_x > max_x) begin
      result_o   = max_i;
      sat_high_o = 1'b1;
    end else begin
      result_o = sum_x[WORD_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/accumulator_binary_saturating.sv
// Saturating signed accumulator with valid/ready operand and result handshakes.
// Optional feature: define ACCUMULATOR_BINARY_SATURATING_STICKY_EN to make the
// saturation flags sticky until clear or a load transfer.
module accumulator_binary_saturating
  import accumulator_binary_saturating_pkg::*;
#(
  parameter int WORD_WIDTH = 0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [WORD_WIDTH-1:0] max_limit,
  input  logic [WORD_WIDTH-1:0] min_limit,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_add_sub,
  input  logic                  in_carry,
  input  logic                  in_load,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_sat_high,
  output logic                  out_sat_low,
  output logic                  out_carry
);

  logic [WORD_WIDTH-1:0] acc_q, acc_d;
  logic                  valid_q, valid_d;
  logic                  sat_high_q, sat_high_d;
  logic                  sat_low_q, sat_low_d;
  logic                  carry_q, carry_d;

  logic [WORD_WIDTH-1:0] dp_result;
  logic                  dp_sat_high;
  logic                  dp_sat_low;
  logic                  dp_carry;
  logic                  in_xfer;
  logic                  out_xfer;

  Adder_Subtractor_Binary_Saturating #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_datapath (
    .acc_i      ($signed(acc_q)),
    .operand_i  ($signed(in_data)),
    .op_i       (in_add_sub),
    .carry_i    (in_carry),
    .load_i     (in_load),
    .max_i      ($signed(max_limit)),
    .min_i      ($signed(min_limit)),
    .result_o   (dp_result),
    .sat_high_o (dp_sat_high),
    .sat_low_o  (dp_sat_low),
    .carry_o    (dp_carry)
  );

  // Ready whenever the result slot is empty or being drained this cycle
  assign in_ready = !valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = valid_q && out_ready;

  // Next-state: capture on input transfer, otherwise drop valid on output transfer
  always_comb begin
    acc_d      = acc_q;
    valid_d    = valid_q;
    sat_high_d = sat_high_q;
    sat_low_d  = sat_low_q;
    carry_d    = carry_q;

    if (in_xfer) begin
      acc_d   = dp_result;
      valid_d = 1'b1;
      carry_d = dp_carry;
`ifdef ACCUMULATOR_BINARY_SATURATING_STICKY_EN
      if (in_load) begin
        sat_high_d = dp_sat_high;
        sat_low_d  = dp_sat_low;
      end else begin
        sat_high_d = sat_high_q | dp_sat_high;
        sat_low_d  = sat_low_q | dp_sat_low;
      end
`else
      sat_high_d = dp_sat_high;
      sat_low_d  = dp_sat_low;
`endif
    end else if (out_xfer) begin
      valid_d = 1'b0;
    end
  end

  // State registers; clear overrides any concurrent transfer
  always_ff @(posedge clock) begin
    if (clear) begin
      acc_q      <= '0;
      valid_q    <= 1'b0;
      sat_high_q <= 1'b0;
      sat_low_q  <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      valid_q    <= valid_d;
      sat_high_q <= sat_high_d;
      sat_low_q  <= sat_low_d;
      carry_q    <= carry_d;
    end
  end

  assign out_data     = acc_q;
  assign out_valid    = valid_q;
  assign out_sat_high = sat_high_q;
  assign out_sat_low  = sat_low_q;
  assign out_carry    = carry_q;

endmodule

// File: tb/tb_accumulator_binary_saturating.sv
// Self-checking bench for accumulator_binary_saturating (WORD_WIDTH=8) against an
// integer-arithmetic reference model.
module tb_accumulator_binary_saturating;

  localparam int W = 8;

  logic         clock;
  logic         clear;
  logic [W-1:0] max_limit;
  logic [W-1:0] min_limit;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_add_sub;
  logic         in_carry;
  logic         in_load;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_sat_high;
  logic         out_sat_low;
  logic         out_carry;

  accumulator_binary_saturating #(.WORD_WIDTH(W)) dut (
    .clock        (clock),
    .clear        (clear),
    .max_limit    (max_limit),
    .min_limit    (min_limit),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_add_sub   (in_add_sub),
    .in_carry     (in_carry),
    .in_load      (in_load),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sat_high (out_sat_high),
    .out_sat_low  (out_sat_low),
    .out_carry    (out_carry)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state (plain integers)
  int m_acc, m_valid, m_hi, m_lo, m_carry;
  int lim_max, lim_min;
  int d_val;
  int n_total, n_pass;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive(input bit v, input int d, input bit sub, input bit c,
                       input bit ld, input bit ordy);
    in_valid   = v;
    d_val      = d;
    in_data    = W'(d);
    in_add_sub = sub;
    in_carry   = c;
    in_load    = ld;
    out_ready  = ordy;
  endtask

  task automatic set_limits(input int mx, input int mn);
    lim_max   = mx;
    lim_min   = mn;
    max_limit = W'(mx);
    min_limit = W'(mn);
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    int r;
    int hi, lo;
    bit rdy, x_in, x_out;
    rdy   = (m_valid == 0) || out_ready;
    x_in  = in_valid && rdy;
    x_out = (m_valid != 0) && out_ready;
    if (clear) begin
      m_acc = 0; m_valid = 0; m_hi = 0; m_lo = 0; m_carry = 0;
    end else if (x_in) begin
      if (in_load)         r = d_val;
      else if (in_add_sub) r = m_acc - d_val - int'(in_carry);
      else                 r = m_acc + d_val + int'(in_carry);
      m_carry = (!in_load && r < 0) ? 1 : 0;
      hi = 0; lo = 0;
      if (r < lim_min) begin
        r = lim_min; lo = 1;
      end else if (r > lim_max) begin
        r = lim_max; hi = 1;
      end
`ifdef ACCUMULATOR_BINARY_SATURATING_STICKY_EN
      if (!in_load) begin
        hi = hi | m_hi;
        lo = lo | m_lo;
      end
`endif
      m_acc = r; m_hi = hi; m_lo = lo; m_valid = 1;
    end else if (x_out) begin
      m_valid = 0;
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    check({tag, "_valid"}, int'(out_valid), m_valid);
    check({tag, "_data"}, int'($signed(out_data)), m_acc);
    check({tag, "_hi"}, int'(out_sat_high), m_hi);
    check({tag, "_lo"}, int'(out_sat_low), m_lo);
    check({tag, "_carry"}, int'(out_carry), m_carry);
    check({tag, "_rdy"}, int'(in_ready), ((m_valid == 0) || out_ready) ? 1 : 0);
  endtask

  initial begin
    int frozen, prev, a, b;
    n_total = 0; n_pass = 0;
    m_acc = 0; m_valid = 0; m_hi = 0; m_lo = 0; m_carry = 0;
    clear = 1'b1;
    set_limits(100, -100);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    tick("rst");
    clear = 1'b0;

    // Add up to the upper limit
    drive(1, 60, 0, 0, 0, 1);
    tick("add60");
    check("add60_abs", int'($signed(out_data)), 60);
    drive(1, 50, 0, 0, 0, 1);
    tick("add50");
    check("add50_abs", int'($signed(out_data)), 100);
    check("add50_sathi", int'(out_sat_high), 1);
    check("add50_carry", int'(out_carry), 0);

    // Load then subtract below the lower limit
    drive(1, -90, 1, 1, 1, 1);
    tick("ld90");
    check("ld90_abs", int'($signed(out_data)), -90);
    drive(1, 20, 1, 0, 0, 1);
    tick("sub20");
    check("sub20_abs", int'($signed(out_data)), -100);
    check("sub20_satlo", int'(out_sat_low), 1);
    drive(1, 5, 0, 0, 0, 1);
    tick("add5");
    check("add5_abs", int'($signed(out_data)), -95);
`ifdef ACCUMULATOR_BINARY_SATURATING_STICKY_EN
    check("add5_satlo", int'(out_sat_low), 1);
`else
    check("add5_satlo", int'(out_sat_low), 0);
`endif

    // Full-range limits: no wrap from 127 to -128
    set_limits(127, -128);
    drive(1, 127, 0, 0, 1, 1);
    tick("ld127");
    drive(1, 1, 0, 0, 0, 1);
    tick("wrap");
    check("wrap_abs", int'($signed(out_data)), 127);
    check("wrap_sathi", int'(out_sat_high), 1);

    // Backpressure: output frozen, then full-throughput drain
    set_limits(100, -100);
    drive(1, 1, 0, 0, 0, 0);
    tick("bp_first");
    frozen = int'($signed(out_data));
    drive(1, 7, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick("bp_hold");
      check("bp_frozen", int'($signed(out_data)), frozen);
      check("bp_notready", int'(in_ready), 0);
    end
    set_limits(127, -128);
    drive(1, -1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      prev = int'($signed(out_data));
      tick("b2b");
      check("b2b_valid", int'(out_valid), 1);
      check("b2b_step", int'($signed(out_data)), prev - 1);
    end

    // Clear with a pending result and a concurrent input
    set_limits(100, -100);
    drive(1, 3, 0, 0, 0, 0);
    clear = 1'b1;
    tick("clr");
    check("clr_valid", int'(out_valid), 0);
    check("clr_data", int'(out_data), 0);
    check("clr_flags", int'({out_sat_high, out_sat_low, out_carry}), 0);
    clear = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick("clr_after");
    check("clr_rdy", int'(in_ready), 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        a = int'($urandom_range(0, 255)) - 128;
        b = int'($urandom_range(0, 255)) - 128;
        if (a >= b) set_limits(a, b);
        else        set_limits(b, a);
      end
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 63) == 0);
      tick("rnd");
    end
    clear = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
